// File: rtl/pgo_pkg.sv
// Shared definitions for the per-channel gain/offset pixel stage: mode codes,
// unity gain and output clamping.
package pgo_pkg;
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GAIN   = 2'd1;
  localparam logic [1:0] MODE_GREY   = 2'd2;

  function automatic int gain_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int clamp_dw(input int v, input int dw);
    int hi;
    hi = (1 << dw) - 1;
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage

// File: rtl/pgo_lane.sv
// One channel lane: registered x*K product, then floor shift, offset add,
// clamp and output register. Bypass multiplies by unity and drops the offset.
module pgo_lane
  import pgo_pkg::*;
#(
  parameter int DW   = 12,
  parameter int KW   = 8,
  parameter int FRAC = 4,
  parameter int CW   = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iEN1,
  input  logic                 iEN2,
  input  logic [1:0]           iMODE,
  input  logic [DW-1:0]        iX,
  input  logic [KW-1:0]        iK,
  input  logic signed [CW-1:0] iC,
  output logic [DW-1:0]        oPIX
);
  localparam int PW = DW + KW;

  logic [PW-1:0] prod_q, prod_d;
  logic          byp_q, byp_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [KW-1:0] k_eff;
  int            sum;

  always_comb begin
    byp_d  = !(iMODE == MODE_GAIN || iMODE == MODE_GREY);
    k_eff  = byp_d ? KW'(gain_one(FRAC)) : iK;
    prod_d = PW'(iX) * PW'(k_eff);
    // product is unsigned, so the shift is a floor; offset is sign-extended
    sum    = int'(prod_q >> FRAC) + (byp_q ? 0 : int'(iC));
    pix_d  = DW'(clamp_dw(sum, DW));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      prod_q <= '0;
      byp_q  <= 1'b0;
      pix_q  <= '0;
    end else begin
      if (iEN1) begin
        prod_q <= prod_d;
        byp_q  <= byp_d;
      end
      if (iEN2) pix_q <= pix_d;
    end
  end

  assign oPIX = pix_q;
endmodule

// File: rtl/pixel_gain_offset_pipe.sv
// NCH-channel gain/offset/grey stage: key edge detect, coefficient register
// file with saturating adjust, source muxes and a 2-stage valid pipeline.
module pixel_gain_offset_pipe
  import pgo_pkg::*;
#(
  parameter int DW   = 12,
  parameter int NCH  = 3,
  parameter int KW   = 8,
  parameter int FRAC = 4,
  parameter int CW   = 8,
  parameter int SW   = $clog2(NCH)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  input  logic [NCH*DW-1:0] iPIX,
  input  logic [1:0]        iMODE,
  input  logic [SW-1:0]     iSRC_SEL,
  input  logic              iINC,
  input  logic              iDEC,
  input  logic              iSEL_C,
  input  logic [SW-1:0]     iCH_SEL,
  output logic              oVALID,
  output logic [NCH*DW-1:0] oPIX,
  output logic [KW-1:0]     oCOEF_K,
  output logic [CW-1:0]     oCOEF_C
);
  localparam int STAGES = 2;
  localparam logic [CW-1:0] C_MAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] C_MIN = {1'b1, {(CW-1){1'b0}}};

  logic [NCH-1:0][KW-1:0] k_q, k_d, k_sel;
  logic [NCH-1:0][CW-1:0] c_q, c_d, c_sel;
  logic [NCH-1:0][DW-1:0] pix_in, pix_out, x_sel;
  logic                   inc_q, dec_q, press_inc, press_dec, ch_ok;
  logic [SW-1:0]          src_eff, src1_q;
  logic [1:0]             mode1_q;
  logic [STAGES:1]        vld_q;

  assign pix_in    = iPIX;
  assign press_inc = iINC & ~inc_q;
  assign press_dec = iDEC & ~dec_q;
  assign ch_ok     = int'(iCH_SEL) < NCH;
  assign src_eff   = (int'(iSRC_SEL) < NCH) ? iSRC_SEL : '0;

  always_comb begin
    k_d = k_q;
    c_d = c_q;
    if (ch_ok && (press_inc ^ press_dec)) begin
      if (!iSEL_C) begin
        if (press_inc && k_q[iCH_SEL] != {KW{1'b1}}) k_d[iCH_SEL] = k_q[iCH_SEL] + KW'(1);
        else if (press_dec && k_q[iCH_SEL] != '0)    k_d[iCH_SEL] = k_q[iCH_SEL] - KW'(1);
      end else begin
        if (press_inc && c_q[iCH_SEL] != C_MAX)      c_d[iCH_SEL] = c_q[iCH_SEL] + CW'(1);
        else if (press_dec && c_q[iCH_SEL] != C_MIN) c_d[iCH_SEL] = c_q[iCH_SEL] - CW'(1);
      end
    end
  end

  // K is taken at stage-1 entry; C is taken at stage 2 using the captured mode/source
  always_comb begin
    for (int l = 0; l < NCH; l++) begin
      x_sel[l] = (iMODE == MODE_GREY)   ? pix_in[src_eff] : pix_in[l];
      k_sel[l] = (iMODE == MODE_GREY)   ? k_q[src_eff]    : k_q[l];
      c_sel[l] = (mode1_q == MODE_GREY) ? c_q[src1_q]     : c_q[l];
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < NCH; i++) k_q[i] <= KW'(gain_one(FRAC));
      c_q     <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      vld_q   <= '0;
      mode1_q <= MODE_BYPASS;
      src1_q  <= '0;
    end else begin
      k_q   <= k_d;
      c_q   <= c_d;
      inc_q <= iINC;
      dec_q <= iDEC;
      vld_q <= {vld_q[STAGES-1:1], iVALID};
      if (iVALID) begin
        mode1_q <= iMODE;
        src1_q  <= src_eff;
      end
    end
  end

  for (genvar l = 0; l < NCH; l++) begin : g_lane
    pgo_lane #(.DW(DW), .KW(KW), .FRAC(FRAC), .CW(CW)) u_lane (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .iEN1  (iVALID),
      .iEN2  (vld_q[1]),
      .iMODE (iMODE),
      .iX    (x_sel[l]),
      .iK    (k_sel[l]),
      .iC    (c_sel[l]),
      .oPIX  (pix_out[l])
    );
  end

  assign oVALID  = vld_q[STAGES];
  assign oPIX    = pix_out;
  assign oCOEF_K = ch_ok ? k_q[iCH_SEL] : '0;
  assign oCOEF_C = ch_ok ? c_q[iCH_SEL] : '0;
endmodule

// File: tb/tb_pixel_gain_offset_pipe.sv
// Bench: directed literal checks plus randomized traffic compared every cycle
// against an arithmetic reference model of the gain/offset pipeline.
module tb_pixel_gain_offset_pipe;
  localparam int DW = 12, NCH = 3, KW = 8, FRAC = 4, CW = 8, SW = 2;

  logic              iCLK = 1'b0, iRST = 1'b1, iVALID = 1'b0;
  logic [NCH*DW-1:0] iPIX = '0;
  logic [1:0]        iMODE = 2'd0;
  logic [SW-1:0]     iSRC_SEL = '0, iCH_SEL = '0;
  logic              iINC = 1'b0, iDEC = 1'b0, iSEL_C = 1'b0;
  logic              oVALID;
  logic [NCH*DW-1:0] oPIX;
  logic [KW-1:0]     oCOEF_K;
  logic [CW-1:0]     oCOEF_C;

  pixel_gain_offset_pipe #(.DW(DW), .NCH(NCH), .KW(KW), .FRAC(FRAC), .CW(CW), .SW(SW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iPIX(iPIX), .iMODE(iMODE),
    .iSRC_SEL(iSRC_SEL), .iINC(iINC), .iDEC(iDEC), .iSEL_C(iSEL_C), .iCH_SEL(iCH_SEL),
    .oVALID(oVALID), .oPIX(oPIX), .oCOEF_K(oCOEF_K), .oCOEF_C(oCOEF_C));

  always #5 iCLK = ~iCLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mk[NCH], mc[NCH], mp[NCH];
  int s1x[NCH], s1k[NCH], s1mode, s1src;
  bit pinc, pdec, s1v, mv;

  function automatic int pix_of(input logic [NCH*DW-1:0] p, input int c);
    return int'((p >> (c * DW)) & ((1 << DW) - 1));
  endfunction

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int c = 0; c < NCH; c++) begin mk[c] = 16; mc[c] = 0; mp[c] = 0; end
      pinc = 0; pdec = 0; s1v = 0; mv = 0;
    end else begin
      bit pi, pd, gr;
      int src, ch, v;
      mv = s1v;
      if (s1v)
        for (int c = 0; c < NCH; c++) begin
          if (s1mode == 1 || s1mode == 2) begin
            v = (s1x[c] * s1k[c]) / 16 + ((s1mode == 2) ? mc[s1src] : mc[c]);
            mp[c] = (v < 0) ? 0 : (v > 4095) ? 4095 : v;
          end else mp[c] = s1x[c];
        end
      s1v = iVALID;
      if (iVALID) begin
        gr = (iMODE == 2);
        src = (int'(iSRC_SEL) < NCH) ? int'(iSRC_SEL) : 0;
        s1mode = int'(iMODE); s1src = src;
        for (int c = 0; c < NCH; c++) begin
          s1x[c] = pix_of(iPIX, gr ? src : c);
          s1k[c] = mk[gr ? src : c];
        end
      end
      pi = iINC && !pinc; pd = iDEC && !pdec;
      pinc = iINC; pdec = iDEC;
      ch = int'(iCH_SEL);
      if ((pi != pd) && ch < NCH) begin
        if (!iSEL_C) mk[ch] = pi ? ((mk[ch] < 255) ? mk[ch] + 1 : 255) : ((mk[ch] > 0) ? mk[ch] - 1 : 0);
        else         mc[ch] = pi ? ((mc[ch] < 127) ? mc[ch] + 1 : 127) : ((mc[ch] > -128) ? mc[ch] - 1 : -128);
      end
    end
  end

  always @(negedge iCLK) begin
    if (!iRST) begin
      int ch;
      ch = int'(iCH_SEL);
      chk("model oVALID", oVALID, mv);
      for (int c = 0; c < NCH; c++) chk("model oPIX", 64'(pix_of(oPIX, c)), 64'(mp[c]));
      chk("model oCOEF_K", oCOEF_K, (ch < NCH) ? 64'(mk[ch]) : 64'd0);
      chk("model oCOEF_C", oCOEF_C, (ch < NCH) ? 64'(mc[ch] & 255) : 64'd0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic press(input logic inc, input logic dec);
    iINC = inc; iDEC = dec; tick(1);
    iINC = 0;   iDEC = 0;   tick(1);
  endtask

  task automatic run_pix(input int b, input int r, input int g, output logic [NCH*DW-1:0] o);
    iPIX = {12'(g), 12'(r), 12'(b)};
    iVALID = 1; tick(1);
    iVALID = 0;
    chk("latency 1 oVALID", oVALID, 0);
    tick(1);
    chk("latency 2 oVALID", oVALID, 1);
    o = oPIX;
    tick(1);
    chk("pulse end oVALID", oVALID, 0);
  endtask

  logic [NCH*DW-1:0] o;

  initial begin
    iRST = 1; tick(2);
    iRST = 0; tick(1);
    chk("reset oVALID", oVALID, 0);
    chk("reset oPIX", oPIX, 0);
    chk("reset coefK", oCOEF_K, 16);
    chk("reset coefC", oCOEF_C, 0);

    iMODE = 0; run_pix(100, 200, 300, o);
    chk("bypass pix", o, {12'd300, 12'd200, 12'd100});

    iMODE = 1; run_pix(1000, 1000, 1000, o);
    chk("unity gain", o, {12'd1000, 12'd1000, 12'd1000});

    iSEL_C = 0; iCH_SEL = 0;
    for (int i = 0; i < 16; i++) press(1, 0);
    chk("gain 32 readback", oCOEF_K, 32);
    run_pix(1000, 1000, 1000, o);
    chk("gain x2", o, {12'd1000, 12'd1000, 12'd2000});
    run_pix(3000, 1000, 1000, o);
    chk("gain clamp hi", o[11:0], 4095);

    iSEL_C = 1; iCH_SEL = 1;
    for (int i = 0; i < 5; i++) press(0, 1);
    chk("offset -5 readback", oCOEF_C, 8'hFB);
    run_pix(0, 100, 0, o);
    chk("offset red 95", o[23:12], 95);
    run_pix(0, 3, 0, o);
    chk("offset clamp lo", o[23:12], 0);

    iSEL_C = 0; iCH_SEL = 0;
    for (int i = 0; i < 223; i++) press(1, 0);
    chk("gain 255", oCOEF_K, 255);
    press(1, 0);
    chk("gain sat hi", oCOEF_K, 255);
    for (int i = 0; i < 255; i++) press(0, 1);
    chk("gain 0", oCOEF_K, 0);
    press(0, 1);
    chk("gain sat lo", oCOEF_K, 0);
    iINC = 1; tick(10); iINC = 0; tick(1);
    chk("held inc once", oCOEF_K, 1);
    press(1, 1);
    chk("inc+dec no change", oCOEF_K, 1);

    iCH_SEL = 3; press(1, 0); #1;
    chk("bad ch coefK", oCOEF_K, 0);
    chk("bad ch coefC", oCOEF_C, 0);

    iSEL_C = 1; iCH_SEL = 2;
    for (int i = 0; i < 10; i++) press(1, 0);
    chk("green offset 10", oCOEF_C, 10);
    iMODE = 2; iSRC_SEL = 2; run_pix(5, 6, 7, o);
    chk("grey src2", o, {12'd17, 12'd17, 12'd17});
    iSRC_SEL = 3; run_pix(5, 6, 7, o);
    chk("grey bad src", o, 0);

    for (int i = 0; i < 3000; i++) begin
      iVALID = 1'($urandom_range(0, 1));
      iPIX = {4'($urandom), 32'($urandom)};
      iMODE = 2'($urandom_range(0, 3));
      iSRC_SEL = 2'($urandom_range(0, 3));
      iINC = ($urandom_range(0, 2) == 0);
      iDEC = ($urandom_range(0, 3) == 0);
      iSEL_C = 1'($urandom_range(0, 1));
      iCH_SEL = 2'($urandom_range(0, 3));
      tick(1);
    end
    iINC = 0; iDEC = 0; iVALID = 0; tick(3);

    iMODE = 1; iCH_SEL = 0; iVALID = 1; iPIX = {12'd50, 12'd60, 12'd70};
    tick(3);
    #3 iRST = 1;
    #1;
    chk("async rst oVALID", oVALID, 0);
    chk("async rst oPIX", oPIX, 0);
    tick(1);
    iVALID = 0;
    #2 iRST = 0;
    for (int c = 0; c < NCH; c++) begin
      iCH_SEL = 2'(c); #1;
      chk("post rst coefK", oCOEF_K, 16);
      chk("post rst coefC", oCOEF_C, 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("no stale oVALID", oVALID, 0);
      chk("no stale oPIX", oPIX, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
